pwm_ramp_ctrl: RTL

- Duty-cycle scheduler for the team's counter-based PWM generator.
- Accepts a target duty and a step size over a valid/ready config port.
- Owns the PWM period counter and moves the active duty toward the target by one step every STEP_PERIODS PWM periods (soft-start / soft-stop).
- Duty changes take effect only at period boundaries, so pwm_out never glitches mid-period.

---
 rtl/pwm_ramp_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: duty-cycle scheduler for a counter-based PWM generator.
// Owns the PWM period counter and ramps the active duty toward a requested
// target by a fixed step every STEP_PERIODS PWM periods. Duty updates only
// land on period boundaries so the waveform never glitches mid-period.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         run enable; low freezes the counter (held at 0) and the ramp
//   cfg_valid  config request valid
//   cfg_ready  high while idle; request accepted on cfg_valid && cfg_ready
//   cfg_duty   target duty in high clocks per period (clamped to PERIOD)
//   cfg_step   ramp increment per step; 0 jumps straight to the target
//   pwm_out    PWM waveform, decoded from the counter and active duty
//   duty_out   currently active duty
//   busy       high while ramping
//   done       one-cycle pulse when the active duty reaches the target
module pwm_ramp_ctrl #(
   parameter int unsigned PERIOD       = 10,
   parameter int unsigned CW           = 5,
   parameter int unsigned STEP_PERIODS = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_duty,
   input  logic [CW-1:0] cfg_step,
   output logic          pwm_out,
   output logic [CW-1:0] duty_out,
   output logic          busy,
   output logic          done
);

   localparam int unsigned PCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t          state;
   logic [CW-1:0]   count;
   logic [CW-1:0]   duty_active;
   logic [CW-1:0]   target;
   logic [CW-1:0]   step;
   logic [PCW-1:0]  per_cnt;

   logic            boundary;
   logic [CW-1:0]   cfg_target;
   logic [CW:0]     duty_x;
   logic [CW:0]     target_x;
   logic [CW:0]     step_x;
   logic [CW:0]     next_duty;

   // Last clock of a running period.
   assign boundary = en && (count == CW'(PERIOD - 1));

   // Requested duty saturated at a full period.
   assign cfg_target = (cfg_duty > CW'(PERIOD)) ? CW'(PERIOD) : cfg_duty;

   // Next ramp value, computed one bit wider so the sum/difference cannot wrap.
   always_comb begin
      duty_x    = {1'b0, duty_active};
      target_x  = {1'b0, target};
      step_x    = {1'b0, step};
      next_duty = target_x;
      if (step != '0) begin
         if (duty_x < target_x) begin
            if ((duty_x + step_x) < target_x)
               next_duty = duty_x + step_x;
         end else if (duty_x > target_x) begin
            if ((duty_x - target_x) > step_x)
               next_duty = duty_x - step_x;
         end
      end
   end

   // Counter, ramp state and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         duty_active <= '0;
         target      <= '0;
         step        <= '0;
         per_cnt     <= '0;
         cfg_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;

         if (!en)
            count <= '0;
         else if (count == CW'(PERIOD - 1))
            count <= '0;
         else
            count <= count + CW'(1);

         case (state)
            IDLE: begin
               if (cfg_valid && cfg_ready) begin
                  target  <= cfg_target;
                  step    <= cfg_step;
                  per_cnt <= '0;
                  if (cfg_target == duty_active) begin
                     done <= 1'b1;
                  end else begin
                     state     <= RAMP;
                     cfg_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            RAMP: begin
               if (boundary) begin
                  if (per_cnt == PCW'(STEP_PERIODS - 1)) begin
                     per_cnt     <= '0;
                     duty_active <= next_duty[CW-1:0];
                     if (next_duty == target_x) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                     end
                  end else begin
                     per_cnt <= per_cnt + PCW'(1);
                  end
               end
            end
         endcase
      end
   end

   // Waveform decode; forced low whenever the generator is disabled.
   assign pwm_out  = en && (count < duty_active);
   assign duty_out = duty_active;

endmodule
